// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates I-cache, D-cache and prefetcher cacheline requests onto one memory port.
// Optional ARB_PF_AGING_EN promotes a starved prefetch after PF_MAX_WAIT bypasses.
module cacheline_mem_arbiter #(
  parameter int unsigned PF_MAX_WAIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_address,
  output logic [255:0] pf_rdata,
  output logic         pf_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned OFF_W  = 5;

  if (PF_MAX_WAIT < 1 || PF_MAX_WAIT > 255) begin : g_bad_wait
    $error("PF_MAX_WAIT must be in 1..255");
  end

  typedef enum logic [2:0] {IDLE, SERVE_D, SERVE_I, SERVE_PF, GAP} state_t;

  state_t              state, state_n;
  logic                mem_read_n, mem_write_n;
  logic [ADDR_W-1:0]   mem_address_n;
  logic [LINE_W-1:0]   mem_wdata_n;
  logic                pf_promote;
  logic                demand_req;

  assign demand_req = d_read || d_write || i_read;

`ifdef ARB_PF_AGING_EN
  localparam int unsigned AGE_W = 8;
  logic [AGE_W-1:0] age, age_n;

  assign pf_promote = pf_read && (age >= AGE_W'(PF_MAX_WAIT));

  // Saturating count of IDLE grants that went to a demand port over a waiting prefetch
  always_comb begin
    age_n = age;
    if (!pf_read) begin
      age_n = '0;
    end else if (state == IDLE) begin
      if (pf_promote || !demand_req) begin
        age_n = '0;
      end else if (age != '1) begin
        age_n = age + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) age <= '0;
    else     age <= age_n;
  end
`else
  assign pf_promote = 1'b0;
`endif

  // Line offset bits never reach memory
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_address[OFF_W-1:0], d_address[OFF_W-1:0],
                                pf_address[OFF_W-1:0]};

  always_comb begin
    state_n       = state;
    mem_read_n    = mem_read;
    mem_write_n   = mem_write;
    mem_address_n = mem_address;
    mem_wdata_n   = mem_wdata;
    case (state)
      IDLE: begin
        if (pf_promote) begin
          state_n       = SERVE_PF;
          mem_read_n    = 1'b1;
          mem_address_n = {pf_address[ADDR_W-1:OFF_W], OFF_W'(0)};
        end else if (d_read || d_write) begin
          // Simultaneous read and write from the D-cache is served as the writeback
          state_n       = SERVE_D;
          mem_write_n   = d_write;
          mem_read_n    = !d_write;
          mem_address_n = {d_address[ADDR_W-1:OFF_W], OFF_W'(0)};
          mem_wdata_n   = d_wdata;
        end else if (i_read) begin
          state_n       = SERVE_I;
          mem_read_n    = 1'b1;
          mem_address_n = {i_address[ADDR_W-1:OFF_W], OFF_W'(0)};
        end else if (pf_read) begin
          state_n       = SERVE_PF;
          mem_read_n    = 1'b1;
          mem_address_n = {pf_address[ADDR_W-1:OFF_W], OFF_W'(0)};
        end
      end
      SERVE_D, SERVE_I, SERVE_PF: begin
        if (mem_resp) begin
          state_n     = GAP;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_n;
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
      mem_address <= mem_address_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

  // Completion goes only to the port being served; mem_resp elsewhere is dropped
  assign d_resp   = (state == SERVE_D)  && mem_resp;
  assign i_resp   = (state == SERVE_I)  && mem_resp;
  assign pf_resp  = (state == SERVE_PF) && mem_resp;
  assign d_rdata  = d_resp  ? mem_rdata : '0;
  assign i_rdata  = i_resp  ? mem_rdata : '0;
  assign pf_rdata = pf_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: cycle table plus reset and aging sequences.
module tb_cacheline_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, pf_read;
  logic [31:0]  i_address, d_address, pf_address;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata, pf_rdata;
  logic         i_resp, d_resp, pf_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks   = 0;
  int failures = 0;
  logic mem_auto = 1'b0;

  localparam logic [31:0]  D_ADDR  = 32'hD000_0047;
  localparam logic [31:0]  I_ADDR  = 32'h1000_0088;
  localparam logic [31:0]  PF_ADDR = 32'h0000_1234;
  localparam logic [255:0] WD = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] RD = {8{32'hCAFE_F00D}};
`ifdef ARB_PF_AGING_EN
  localparam int EXP_BYPASS = 4;
`else
  localparam int EXP_BYPASS = 6;
`endif

  cacheline_mem_arbiter #(.PF_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pf_read(pf_read), .pf_address(pf_address), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dr, dw, ir, pr, mr;
    logic e_rd, e_wr, e_d, e_i, e_pf;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[$];

  // b = {dr,dw,ir,pr,mr, rd,wr,dresp,iresp,pfresp}; sel: 0 none, 1 D, 2 I, 3 PF address
  function automatic vec_t mk(input logic [9:0] b, input logic [1:0] sel);
    vec_t v;
    v.dr = b[9]; v.dw = b[8]; v.ir = b[7]; v.pr = b[6]; v.mr = b[5];
    v.e_rd = b[4]; v.e_wr = b[3]; v.e_d = b[2]; v.e_i = b[1]; v.e_pf = b[0];
    v.sel = sel;
    return v;
  endfunction

  function automatic logic [31:0] line_of(input logic [1:0] sel);
    case (sel)
      2'd1:    return 32'hD000_0040;
      2'd2:    return 32'h1000_0080;
      2'd3:    return 32'h0000_1220;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: answers LAT cycles into a strobe with data derived from the line address
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (mem_resp) begin
          mem_resp = 1'b0;
          cnt = 0;
        end else if (mem_read || mem_write) begin
          cnt++;
          if (cnt >= 3) begin
            mem_resp  = 1'b1;
            mem_rdata = {8{mem_address}};
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : main
    logic done;
    int   n_i;
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pf_read = 1'b0;
    i_address = I_ADDR; d_address = D_ADDR; pf_address = PF_ADDR;
    d_wdata = WD; mem_rdata = RD; mem_resp = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_read",  256'(mem_read),  256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_mem_addr",  256'(mem_address), 256'(0));
    chk("rst_mem_wdata", mem_wdata, 256'(0));
    chk("rst_d_resp",  256'(d_resp),  256'(0));
    chk("rst_i_resp",  256'(i_resp),  256'(0));
    chk("rst_pf_resp", 256'(pf_resp), 256'(0));
    rst = 1'b0;

    // PF alone, stale mem_resp in GAP and IDLE
    vecs.push_back(mk(10'b00010_00000, 2'd0));
    vecs.push_back(mk(10'b00010_10000, 2'd3));
    vecs.push_back(mk(10'b00010_10000, 2'd3));
    vecs.push_back(mk(10'b00010_10000, 2'd3));
    vecs.push_back(mk(10'b00011_10001, 2'd3));
    vecs.push_back(mk(10'b00001_00000, 2'd0));
    vecs.push_back(mk(10'b00000_00000, 2'd0));
    vecs.push_back(mk(10'b00001_00000, 2'd0));
    // D write, I, PF all at once: serve order D, I, PF
    vecs.push_back(mk(10'b01110_00000, 2'd0));
    vecs.push_back(mk(10'b01110_01000, 2'd1));
    vecs.push_back(mk(10'b01111_01100, 2'd1));
    vecs.push_back(mk(10'b00110_00000, 2'd0));
    vecs.push_back(mk(10'b00110_00000, 2'd0));
    vecs.push_back(mk(10'b00110_10000, 2'd2));
    vecs.push_back(mk(10'b00111_10010, 2'd2));
    vecs.push_back(mk(10'b00010_00000, 2'd0));
    vecs.push_back(mk(10'b00010_00000, 2'd0));
    vecs.push_back(mk(10'b00010_10000, 2'd3));
    vecs.push_back(mk(10'b00011_10001, 2'd3));
    vecs.push_back(mk(10'b00000_00000, 2'd0));
    vecs.push_back(mk(10'b00000_00000, 2'd0));
    // D read and write together is a write; then plain D read
    vecs.push_back(mk(10'b11000_00000, 2'd0));
    vecs.push_back(mk(10'b11000_01000, 2'd1));
    vecs.push_back(mk(10'b11001_01100, 2'd1));
    vecs.push_back(mk(10'b10000_00000, 2'd0));
    vecs.push_back(mk(10'b10000_00000, 2'd0));
    vecs.push_back(mk(10'b10000_10000, 2'd1));
    vecs.push_back(mk(10'b10001_10100, 2'd1));
    vecs.push_back(mk(10'b00000_00000, 2'd0));
    vecs.push_back(mk(10'b00000_00000, 2'd0));
    // PF granted, I arrives next cycle: no preemption, I served 2 cycles after pf_resp
    vecs.push_back(mk(10'b00010_00000, 2'd0));
    vecs.push_back(mk(10'b00110_10000, 2'd3));
    vecs.push_back(mk(10'b00110_10000, 2'd3));
    vecs.push_back(mk(10'b00111_10001, 2'd3));
    vecs.push_back(mk(10'b00100_00000, 2'd0));
    vecs.push_back(mk(10'b00100_00000, 2'd0));
    vecs.push_back(mk(10'b00100_10000, 2'd2));
    vecs.push_back(mk(10'b00101_10010, 2'd2));
    vecs.push_back(mk(10'b00000_00000, 2'd0));

    foreach (vecs[k]) begin
      @(negedge clk);
      d_read = vecs[k].dr; d_write = vecs[k].dw; i_read = vecs[k].ir;
      pf_read = vecs[k].pr; mem_resp = vecs[k].mr;
      #1;
      chk($sformatf("v%0d_mem_read", k),  256'(mem_read),  256'(vecs[k].e_rd));
      chk($sformatf("v%0d_mem_write", k), 256'(mem_write), 256'(vecs[k].e_wr));
      chk($sformatf("v%0d_d_resp", k),  256'(d_resp),  256'(vecs[k].e_d));
      chk($sformatf("v%0d_i_resp", k),  256'(i_resp),  256'(vecs[k].e_i));
      chk($sformatf("v%0d_pf_resp", k), 256'(pf_resp), 256'(vecs[k].e_pf));
      chk($sformatf("v%0d_d_rdata", k),  d_rdata,  vecs[k].e_d  ? RD : 256'(0));
      chk($sformatf("v%0d_i_rdata", k),  i_rdata,  vecs[k].e_i  ? RD : 256'(0));
      chk($sformatf("v%0d_pf_rdata", k), pf_rdata, vecs[k].e_pf ? RD : 256'(0));
      if (vecs[k].sel != 2'd0)
        chk($sformatf("v%0d_mem_addr", k), 256'(mem_address), 256'(line_of(vecs[k].sel)));
      if (vecs[k].e_wr)
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, WD);
    end

    // Reset while SERVE_D waits on memory, then a stale mem_resp
    @(negedge clk); d_read = 1'b1;
    @(negedge clk); #1;
    chk("rstmid_pre_read", 256'(mem_read), 256'(1));
    rst = 1'b1; d_read = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_read",  256'(mem_read),  256'(0));
    chk("rstmid_write", 256'(mem_write), 256'(0));
    chk("rstmid_addr",  256'(mem_address), 256'(0));
    rst = 1'b0; mem_resp = 1'b1;
    #1;
    chk("stale_d_resp",  256'(d_resp),  256'(0));
    chk("stale_d_rdata", d_rdata, 256'(0));
    @(negedge clk); mem_resp = 1'b0; #1;
    chk("stale_no_grant", 256'(mem_read), 256'(0));

    mem_auto = 1'b1;
    pf_read = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (pf_resp) begin
        done = 1'b1;
        chk("post_rst_pf_rdata", pf_rdata, {8{32'h0000_1220}});
        pf_read = 1'b0;
        break;
      end
    end
    chk("post_rst_pf_done", 256'(done), 256'(1));

    // Starvation: PF held while I keeps requesting
    repeat (4) @(negedge clk);
    pf_read = 1'b1; i_read = 1'b1;
    n_i = 0; done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (i_resp) begin
        n_i++;
        if (n_i == 6) i_read = 1'b0;
      end
      if (pf_resp) begin
        done = 1'b1;
        chk("aging_pf_rdata", pf_rdata, {8{32'h0000_1220}});
        pf_read = 1'b0; i_read = 1'b0;
        break;
      end
    end
    chk("aging_pf_done", 256'(done), 256'(1));
    chk("aging_i_bypasses", 256'(n_i), 256'(EXP_BYPASS));
    pf_read = 1'b0; i_read = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("final_idle_read", 256'(mem_read), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
